seq_detect_multi: RTL and testbench



---
 rtl/seq_detect_pkg.sv | 26 ++
 rtl/seq_match_chan.sv | 85 ++++++++
 rtl/seq_detect_multi.sv | 89 ++++++++
 tb/tb_seq_detect_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types for the multi-pattern serial sequence detector: the per-channel
// configuration record, its power-on value and a length-to-mask helper.
package seq_detect_pkg;

   localparam int SEQ_MAX = 16;
   localparam int LEN_W   = 5;

   typedef struct packed {
      logic [SEQ_MAX-1:0] pattern;
      logic [SEQ_MAX-1:0] mask;
      logic [LEN_W-1:0]   len;
      logic               ovl;
   } chan_cfg_t;

   // Out of reset every channel is disabled (len 0), compares all bits and overlaps.
   localparam chan_cfg_t CHAN_CFG_RST = '{pattern: '0, mask: '1, len: '0, ovl: 1'b1};

   function automatic logic [SEQ_MAX-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [SEQ_MAX-1:0] m;
      for (int b = 0; b < SEQ_MAX; b++) begin
         m[b] = (LEN_W'(b) < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_match_chan.sv
// One detector channel: holds its configuration, fill count, match pulse and
// saturating hit counter; compares against the shared history from the top.
module seq_match_chan
   import seq_detect_pkg::*;
#(
   parameter int SEQ_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SEQ_LEN-1:0] hist_nxt_i,
   input  logic               bit_vld_i,
   input  logic               flush_i,
   input  logic               cfg_load_i,
   input  chan_cfg_t          cfg_i,
   input  logic               cnt_clr_i,
   output logic               seen_o,
   output logic               seen_d_o,
   output logic [CNT_W-1:0]   hit_cnt_o
);

   localparam int FILL_W = $clog2(SEQ_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SEQ_LEN);
   localparam logic [LEN_W-1:0]  LEN_LIMIT = LEN_W'(SEQ_LEN);

   chan_cfg_t          cfg_q;
   logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
   logic               seen_q, seen_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEQ_MAX-1:0] lmask;
   logic [SEQ_LEN-1:0] care;
   logic               enabled, bits_ok, match;
   logic               cfg_unused;

   // Pattern/mask bits above SEQ_LEN are stored but never compared.
   assign cfg_unused = ^{cfg_q.pattern, cfg_q.mask};

   always_comb begin
      fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      enabled  = (cfg_q.len != '0) && (cfg_q.len <= LEN_LIMIT);
      lmask    = len_mask(cfg_q.len);
      care     = cfg_q.mask[SEQ_LEN-1:0] & lmask[SEQ_LEN-1:0];
      bits_ok  = ((hist_nxt_i ^ cfg_q.pattern[SEQ_LEN-1:0]) & care) == '0;
      // A channel being reconfigured on this edge does not see the incoming bit.
      match    = bit_vld_i && !cfg_load_i && enabled && bits_ok &&
                 (LEN_W'(fill_inc) >= cfg_q.len);

      fill_d = fill_q;
      if (cfg_load_i || flush_i) begin
         fill_d = '0;
      end else if (bit_vld_i) begin
         fill_d = (match && !cfg_q.ovl) ? '0 : fill_inc;
      end

      seen_d = match;

      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (match && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_q  <= CHAN_CFG_RST;
         fill_q <= '0;
         seen_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (cfg_load_i) begin
            cfg_q <= cfg_i;
         end
         fill_q <= fill_d;
         seen_q <= seen_d;
         cnt_q  <= cnt_d;
      end
   end

   assign seen_o    = seen_q;
   assign seen_d_o  = seen_d;
   assign hit_cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_multi.sv
// Multi-channel serial pattern detector: one shared bit history feeding
// NUM_PAT independently configured match channels.
module seq_detect_multi
   import seq_detect_pkg::*;
#(
   parameter int SEQ_LEN = 8,
   parameter int NUM_PAT = 4,
   parameter int CNT_W   = 8
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            din,
   input  logic                                            din_valid,
   input  logic                                            flush,
   input  logic                                            cfg_we,
   input  logic [((NUM_PAT > 1) ? $clog2(NUM_PAT) : 1)-1:0] cfg_idx,
   input  logic [SEQ_LEN-1:0]                              cfg_pattern,
   input  logic [SEQ_LEN-1:0]                              cfg_mask,
   input  logic [$clog2(SEQ_LEN+1)-1:0]                    cfg_len,
   input  logic                                            cfg_ovl,
   input  logic                                            cnt_clr,
   output logic [NUM_PAT-1:0]                              seen,
   output logic                                            seen_any,
   output logic [NUM_PAT*CNT_W-1:0]                        hit_cnt
);

   localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

   logic [SEQ_LEN-1:0] hist_q, hist_d, hist_shift;
   logic               bit_vld;
   logic               seen_any_q;
   logic [NUM_PAT-1:0] seen_d;
   chan_cfg_t          cfg_new;

   // Flush takes priority over a simultaneous valid bit.
   assign bit_vld    = din_valid && !flush;
   assign hist_shift = {hist_q[SEQ_LEN-2:0], din};

   always_comb begin
      hist_d = hist_q;
      if (flush) begin
         hist_d = '0;
      end else if (bit_vld) begin
         hist_d = hist_shift;
      end

      cfg_new         = CHAN_CFG_RST;
      cfg_new.pattern = SEQ_MAX'(cfg_pattern);
      cfg_new.mask    = SEQ_MAX'(cfg_mask);
      cfg_new.len     = LEN_W'(cfg_len);
      cfg_new.ovl     = cfg_ovl;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q     <= '0;
         seen_any_q <= 1'b0;
      end else begin
         hist_q     <= hist_d;
         seen_any_q <= |seen_d;
      end
   end

   // An out-of-range cfg_idx matches no channel, so the write is dropped.
   for (genvar i = 0; i < NUM_PAT; i++) begin : g_chan
      logic cfg_load;
      assign cfg_load = cfg_we && (cfg_idx == IDX_W'(i));

      seq_match_chan #(
         .SEQ_LEN (SEQ_LEN),
         .CNT_W   (CNT_W)
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .hist_nxt_i (hist_shift),
         .bit_vld_i  (bit_vld),
         .flush_i    (flush),
         .cfg_load_i (cfg_load),
         .cfg_i      (cfg_new),
         .cnt_clr_i  (cnt_clr),
         .seen_o     (seen[i]),
         .seen_d_o   (seen_d[i]),
         .hit_cnt_o  (hit_cnt[i*CNT_W +: CNT_W])
      );
   end

   assign seen_any = seen_any_q;

endmodule

// File: tb/tb_seq_detect_multi.sv
// Directed table-driven bench for seq_detect_multi (3 channels, 2-bit counters)
// plus hand-written reset sequences.
module tb_seq_detect_multi;

   localparam int SEQ_LEN = 8;
   localparam int NUM_PAT = 3;
   localparam int CNT_W   = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     din, din_valid, flush, cfg_we, cfg_ovl, cnt_clr;
   logic [1:0]               cfg_idx;
   logic [SEQ_LEN-1:0]       cfg_pattern, cfg_mask;
   logic [3:0]               cfg_len;
   logic [NUM_PAT-1:0]       seen;
   logic                     seen_any;
   logic [NUM_PAT*CNT_W-1:0] hit_cnt;

   typedef struct {
      logic       din, vld, fl, clr, we, ovl;
      logic [1:0] idx;
      logic [7:0] pat, mask;
      logic [3:0] len;
      logic [2:0] exp_seen;
      logic [5:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   seq_detect_multi #(.SEQ_LEN(SEQ_LEN), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .flush       (flush),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_pattern (cfg_pattern),
      .cfg_mask    (cfg_mask),
      .cfg_len     (cfg_len),
      .cfg_ovl     (cfg_ovl),
      .cnt_clr     (cnt_clr),
      .seen        (seen),
      .seen_any    (seen_any),
      .hit_cnt     (hit_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t blank(input logic [2:0] s, input logic [5:0] c);
      vec_t v;
      v.din = 1'b0; v.vld = 1'b0; v.fl = 1'b0; v.clr = 1'b0; v.we = 1'b0; v.ovl = 1'b0;
      v.idx = '0; v.pat = '0; v.mask = '0; v.len = '0;
      v.exp_seen = s; v.exp_cnt = c;
      return v;
   endfunction

   function automatic vec_t bv(input logic d, input logic [2:0] s, input logic [5:0] c);
      vec_t v = blank(s, c);
      v.din = d; v.vld = 1'b1;
      return v;
   endfunction

   function automatic vec_t idle(input logic [5:0] c);
      return blank(3'b000, c);
   endfunction

   function automatic vec_t fl(input logic [5:0] c);
      vec_t v = blank(3'b000, c);
      v.fl = 1'b1;
      return v;
   endfunction

   function automatic vec_t cfg(input logic [1:0] idx, input logic [7:0] pat, input logic [7:0] mask,
                                input logic [3:0] len, input logic ovl, input logic [5:0] c);
      vec_t v = blank(3'b000, c);
      v.we = 1'b1; v.idx = idx; v.pat = pat; v.mask = mask; v.len = len; v.ovl = ovl;
      return v;
   endfunction

   task automatic drive_idle();
      din = 1'b0; din_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; cfg_we = 1'b0;
      cfg_idx = '0; cfg_pattern = '0; cfg_mask = '0; cfg_len = '0; cfg_ovl = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [2:0] es, input logic [5:0] ec);
      n_vec++;
      if (seen !== es || seen_any !== (|es) || hit_cnt !== ec) begin
         n_err++;
         $display("FAIL %s: seen=%b seen_any=%b hit_cnt=%b expected seen=%b seen_any=%b hit_cnt=%b",
                  tag, seen, seen_any, hit_cnt, es, |es, ec);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      din = v.din; din_valid = v.vld; flush = v.fl; cnt_clr = v.clr; cfg_we = v.we;
      cfg_idx = v.idx; cfg_pattern = v.pat; cfg_mask = v.mask; cfg_len = v.len; cfg_ovl = v.ovl;
      @(posedge clk);
      #1;
      check_out(tag, v.exp_seen, v.exp_cnt);
   endtask

   initial begin
      vec_t v;
      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      check_out("reset_state", 3'b000, 6'b000000);
      @(negedge clk);
      reset = 1'b0;

      // All channels disabled after reset: zeros never match.
      repeat (3) vecs.push_back(bv(1'b0, 3'b000, 6'b000000));
      // Single 5-bit pattern 10110 on ch0.
      vecs.push_back(cfg(2'd0, 8'b10110, 8'h1F, 4'd5, 1'b1, 6'b000000));
      vecs.push_back(bv(1'b1, 3'b000, 6'b000000));
      vecs.push_back(bv(1'b0, 3'b000, 6'b000000));
      vecs.push_back(bv(1'b1, 3'b000, 6'b000000));
      vecs.push_back(bv(1'b1, 3'b000, 6'b000000));
      vecs.push_back(bv(1'b0, 3'b001, 6'b000001));
      vecs.push_back(idle(6'b000001));
      // Overlapping (ch0) vs non-overlapping (ch1) 101.
      vecs.push_back(cfg(2'd0, 8'b101, 8'h07, 4'd3, 1'b1, 6'b000001));
      vecs.push_back(cfg(2'd1, 8'b101, 8'h07, 4'd3, 1'b0, 6'b000001));
      vecs.push_back(bv(1'b1, 3'b000, 6'b000001));
      vecs.push_back(bv(1'b0, 3'b000, 6'b000001));
      vecs.push_back(bv(1'b1, 3'b011, 6'b000110));
      vecs.push_back(bv(1'b0, 3'b000, 6'b000110));
      vecs.push_back(bv(1'b1, 3'b001, 6'b000111));
      // Don't-care middle bit on ch2.
      vecs.push_back(cfg(2'd2, 8'b101, 8'b101, 4'd3, 1'b1, 6'b000111));
      vecs.push_back(bv(1'b1, 3'b000, 6'b000111));
      vecs.push_back(bv(1'b1, 3'b000, 6'b000111));
      vecs.push_back(bv(1'b1, 3'b100, 6'b010111));
      vecs.push_back(fl(6'b010111));
      vecs.push_back(bv(1'b1, 3'b000, 6'b010111));
      vecs.push_back(bv(1'b1, 3'b000, 6'b010111));
      vecs.push_back(bv(1'b0, 3'b000, 6'b010111));
      // Flush breaks a partial match and beats a simultaneous valid bit; gaps do not.
      vecs.push_back(fl(6'b010111));
      vecs.push_back(bv(1'b1, 3'b000, 6'b010111));
      vecs.push_back(bv(1'b0, 3'b000, 6'b010111));
      v = fl(6'b010111); v.din = 1'b1; v.vld = 1'b1;
      vecs.push_back(v);
      vecs.push_back(bv(1'b1, 3'b000, 6'b010111));
      vecs.push_back(idle(6'b010111));
      vecs.push_back(bv(1'b0, 3'b000, 6'b010111));
      vecs.push_back(idle(6'b010111));
      vecs.push_back(idle(6'b010111));
      vecs.push_back(bv(1'b1, 3'b111, 6'b101011));
      // Config write on the same edge as a matching bit: ch1 skips it; counters saturate.
      vecs.push_back(fl(6'b101011));
      vecs.push_back(bv(1'b1, 3'b000, 6'b101011));
      vecs.push_back(bv(1'b0, 3'b000, 6'b101011));
      v = cfg(2'd1, 8'b101, 8'h07, 4'd3, 1'b0, 6'b111011); v.din = 1'b1; v.vld = 1'b1; v.exp_seen = 3'b101;
      vecs.push_back(v);
      vecs.push_back(bv(1'b0, 3'b000, 6'b111011));
      vecs.push_back(bv(1'b1, 3'b101, 6'b111011));
      // Out-of-range channel index is ignored.
      vecs.push_back(cfg(2'd3, 8'b000, 8'h07, 4'd3, 1'b0, 6'b111011));
      vecs.push_back(fl(6'b111011));
      repeat (3) vecs.push_back(bv(1'b0, 3'b000, 6'b111011));
      vecs.push_back(bv(1'b1, 3'b000, 6'b111011));
      vecs.push_back(bv(1'b0, 3'b000, 6'b111011));
      vecs.push_back(bv(1'b1, 3'b111, 6'b111111));
      // Counter clear, alone and against a simultaneous match.
      v = idle(6'b000000); v.clr = 1'b1;
      vecs.push_back(v);
      vecs.push_back(bv(1'b0, 3'b000, 6'b000000));
      v = bv(1'b1, 3'b101, 6'b000000); v.clr = 1'b1;
      vecs.push_back(v);
      vecs.push_back(bv(1'b0, 3'b000, 6'b000000));
      vecs.push_back(bv(1'b1, 3'b111, 6'b010101));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset between edges while seen and counters are nonzero.
      drive_idle();
      #2;
      reset = 1'b1;
      #1;
      check_out("async_reset", 3'b000, 6'b000000);
      @(negedge clk);
      check_out("reset_held", 3'b000, 6'b000000);
      reset = 1'b0;

      // Configuration returns to disabled defaults.
      apply(bv(1'b0, 3'b000, 6'b000000), "post_reset0");
      apply(bv(1'b0, 3'b000, 6'b000000), "post_reset1");
      apply(bv(1'b1, 3'b000, 6'b000000), "post_reset2");
      apply(bv(1'b0, 3'b000, 6'b000000), "post_reset3");
      apply(bv(1'b1, 3'b000, 6'b000000), "post_reset4");
      drive_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
